fft_frame_feeder: RTL and testbench
===================================

# fft_frame_feeder

Source side of the FFT magnitude chain: accepts signed 16-bit PCM audio samples, converts each to IEEE-754 single precision, and drives the FFT core's AXI4-Stream config and data slave ports. The block issues the transform configuration word after reset or on request, then streams samples as complex beats (real = sample, imaginary = 0.0) and marks every `FRAME_LEN`-th beat with `tlast`. It sits between the audio capture path and `FFTCore_TopModule`.

## Interface
- `FRAME_LEN`, 1024: samples per FFT frame; power of two, 8..65536.
- `aclk`  in  1  single clock; all logic on rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `sample_tdata`  in  16  signed two's-complement PCM sample.
- `sample_tvalid`  in  1  sample present.
- `sample_tready`  out  1  block accepts sample this cycle.
- `cfg_word`  in  16  FFT config word; sampled on entry to CONFIG.
- `cfg_req`  in  1  one-cycle pulse: reissue config at the next frame boundary.
- `m_axis_config_tdata`  out  16  config word to FFT core.
- `m_axis_config_tvalid`  out  1  config beat valid.
- `m_axis_config_tready`  in  1  FFT core accepts config.
- `m_axis_data_tdata`  out  64  [31:0] real float32, [63:32] imaginary float32, always 32'h0.
- `m_axis_data_tvalid`  out  1  data beat valid.
- `m_axis_data_tready`  in  1  FFT core accepts data.
- `m_axis_data_tlast`  out  1  last beat of frame.
- `frame_done`  out  1  one-cycle pulse when a tlast beat handshakes.
- `frame_count`  out  16  completed frames, wraps at 65535 -> 0.

## Operation
- States: CONFIG, STREAM.
- Reset: state CONFIG; `m_axis_config_tvalid` = 0, `m_axis_config_tdata` = 0, `m_axis_data_tvalid` = 0, `m_axis_data_tdata` = 0, `m_axis_data_tlast` = 0, `sample_tready` = 0, `frame_done` = 0, `frame_count` = 0, sample index = 0, pending request = 0.
- CONFIG entry: register `cfg_word` into `m_axis_config_tdata` and set `m_axis_config_tvalid` = 1 on the same edge. Hold both until `m_axis_config_tvalid && m_axis_config_tready`, then clear tvalid and go to STREAM. `sample_tready` = 0 throughout CONFIG.
- STREAM: `sample_tready` = `!m_axis_data_tvalid || m_axis_data_tready`, combinational. This is a single output register with pass-through backpressure.
- On sample handshake: load the converted float into `tdata[31:0]`, set tvalid, set `tlast` = (index == `FRAME_LEN`-1), and advance the index modulo `FRAME_LEN`.
- If the output register drains with no new sample, `m_axis_data_tvalid` drops to 0.
- Conversion of x to float32, exact with no rounding:
  - x = 0 gives 32'h00000000.
  - Otherwise sign = x[15], magnitude m = |x| (17-bit, so -32768 is handled), p = index of the MSB of m.
  - exponent = 127 + p; mantissa = (m << (23 - p))[22:0].
- `cfg_req`: latched into the pending flag while in STREAM. Pulses arriving in CONFIG are ignored.
- Pending flag in STREAM: when index == 0 and the output register is empty (or is handshaking its tlast beat this cycle), `sample_tready` goes to 0 and the block enters CONFIG. The pending flag clears on entry.
- A frame is never split by reconfiguration.
- `frame_done` and the `frame_count` increment both occur in the cycle after the tlast handshake.

## Timing
- First config tvalid: first rising edge after `aresetn` is released.
- Sample-to-output latency: 1 cycle (handshake at edge n, beat valid after edge n).
- Throughput: 1 sample/cycle when the core holds tready high.
- Output tdata, tvalid and tlast are stable while tvalid && !tready (AXI rule).
- Reset asserted mid-frame: everything returns to reset values immediately. No partial frame is resumed, and the next frame starts at index 0 after the config is reissued.
- When a sample handshake and an output handshake coincide, the register reloads with no bubble.

## Test plan
- Reset release, `cfg_word`=16'h0001, config tready held high: config tvalid high for 1 cycle with tdata 16'h0001; `sample_tready` first rises the next cycle.
- Stream samples 0, 1, -1, 256, 32767, -32768: real words 00000000, 3F800000, BF800000, 43800000, 46FFFE00, C7000000; imaginary always 0.
- `FRAME_LEN`=8, 20 samples with tready high: tlast on beats 7 and 15; `frame_done` pulses twice; `frame_count` = 2; beat 16 carries index 0.
- Random data-tready backpressure (50%): no sample lost or duplicated; tdata stable while stalled; output sequence equals input sequence.
- `cfg_req` at beat 3 of a frame with `cfg_word`=16'h0000: the frame completes through tlast, then a config beat with 16'h0000 is sent; no samples are accepted until the config handshake.
- `aresetn` pulsed low at beat 5 of a frame: all outputs return to 0 asynchronously; after release, config reissues and the next tlast falls on beat `FRAME_LEN`-1 counting from the restart.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: converts signed 16-bit PCM into complex float32 AXI-Stream beats
// for the FFT core, issuing the config word after reset or on request at frame boundaries.
`default_nettype none

module fft_frame_feeder #(
    parameter int FRAME_LEN = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] sample_tdata,
    input  logic        sample_tvalid,
    output logic        sample_tready,
    input  logic [15:0] cfg_word,
    input  logic        cfg_req,
    output logic [15:0] m_axis_config_tdata,
    output logic        m_axis_config_tvalid,
    input  logic        m_axis_config_tready,
    output logic [63:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready,
    output logic        m_axis_data_tlast,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        CONFIG = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sample_idx;
    logic             cfg_pending;

    logic             out_free;
    logic             go_config;
    logic             sample_hs;
    logic             data_hs;
    logic [16:0]      mag;
    logic [3:0]       msb_pos;
    logic [4:0]       shift_amt;
    logic [22:0]      mantissa;
    logic [7:0]       exponent;
    logic [31:0]      float_word;

    // Magnitude is 17 bits so that -32768 negates without overflow.
    always_comb begin
        mag = sample_tdata[15] ? (17'd0 - {1'b1, sample_tdata}) : {1'b0, sample_tdata};
        msb_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) msb_pos = 4'(i);
        end
        shift_amt  = 5'd23 - {1'b0, msb_pos};
        mantissa   = 23'({7'd0, mag} << shift_amt);
        exponent   = 8'd127 + {4'd0, msb_pos};
        float_word = (mag == 17'd0) ? 32'h0000_0000 : {sample_tdata[15], exponent, mantissa};
    end

    // Reconfiguration only ever starts with the previous frame's tlast beat gone.
    assign out_free      = !m_axis_data_tvalid || m_axis_data_tready;
    assign go_config     = (state == STREAM) && cfg_pending && (sample_idx == '0) && out_free;
    assign sample_tready = (state == STREAM) && out_free && !go_config;
    assign sample_hs     = sample_tvalid && sample_tready;
    assign data_hs       = m_axis_data_tvalid && m_axis_data_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state                <= CONFIG;
            sample_idx           <= '0;
            cfg_pending          <= 1'b0;
            m_axis_config_tdata  <= 16'h0000;
            m_axis_config_tvalid <= 1'b0;
            m_axis_data_tdata    <= 64'h0;
            m_axis_data_tvalid   <= 1'b0;
            m_axis_data_tlast    <= 1'b0;
            frame_done           <= 1'b0;
            frame_count          <= 16'h0000;
        end else begin
            frame_done <= data_hs && m_axis_data_tlast;
            if (data_hs && m_axis_data_tlast) begin
                frame_count <= frame_count + 16'd1;
            end

            if (sample_hs) begin
                m_axis_data_tdata  <= {32'h0000_0000, float_word};
                m_axis_data_tvalid <= 1'b1;
                m_axis_data_tlast  <= (sample_idx == LAST_IDX);
                sample_idx         <= sample_idx + 1'b1;
            end else if (m_axis_data_tready) begin
                m_axis_data_tvalid <= 1'b0;
            end

            case (state)
                CONFIG: begin
                    // tvalid low here only on the first cycle after reset.
                    if (!m_axis_config_tvalid) begin
                        m_axis_config_tdata  <= cfg_word;
                        m_axis_config_tvalid <= 1'b1;
                    end else if (m_axis_config_tready) begin
                        m_axis_config_tvalid <= 1'b0;
                        state                <= STREAM;
                    end
                end
                STREAM: begin
                    if (go_config) begin
                        state                <= CONFIG;
                        cfg_pending          <= 1'b0;
                        m_axis_config_tdata  <= cfg_word;
                        m_axis_config_tvalid <= 1'b1;
                    end else if (cfg_req) begin
                        cfg_pending <= 1'b1;
                    end
                end
                default: state <= CONFIG;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed self-checking bench for fft_frame_feeder with FRAME_LEN = 8.
`default_nettype none

module tb_fft_frame_feeder;

    localparam int FL = 8;

    logic        aclk;
    logic        aresetn;
    logic [15:0] sample_tdata;
    logic        sample_tvalid;
    logic        sample_tready;
    logic [15:0] cfg_word;
    logic        cfg_req;
    logic [15:0] m_axis_config_tdata;
    logic        m_axis_config_tvalid;
    logic        m_axis_config_tready;
    logic [63:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready;
    logic        m_axis_data_tlast;
    logic        frame_done;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] conv_in  [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0100, 16'h7FFF, 16'h8000};
    logic [31:0] conv_exp [6] = '{32'h00000000, 32'h3F800000, 32'hBF800000,
                                  32'h43800000, 32'h46FFFE00, 32'hC7000000};

    logic [15:0] bp_in  [12] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0100, 16'h7FFF, 16'h8000,
                                 16'h0002, 16'hFFFE, 16'h0003, 16'h0400, 16'hFFFB, 16'h0064};
    logic [31:0] bp_exp [12] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h43800000,
                                 32'h46FFFE00, 32'hC7000000, 32'h40000000, 32'hC0000000,
                                 32'h40400000, 32'h44800000, 32'hC0A00000, 32'h42C80000};

    fft_frame_feeder #(.FRAME_LEN(FL)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .sample_tdata         (sample_tdata),
        .sample_tvalid        (sample_tvalid),
        .sample_tready        (sample_tready),
        .cfg_word             (cfg_word),
        .cfg_req              (cfg_req),
        .m_axis_config_tdata  (m_axis_config_tdata),
        .m_axis_config_tvalid (m_axis_config_tvalid),
        .m_axis_config_tready (m_axis_config_tready),
        .m_axis_data_tdata    (m_axis_data_tdata),
        .m_axis_data_tvalid   (m_axis_data_tvalid),
        .m_axis_data_tready   (m_axis_data_tready),
        .m_axis_data_tlast    (m_axis_data_tlast),
        .frame_done           (frame_done),
        .frame_count          (frame_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset_and_config(input logic [15:0] word);
        aresetn              = 1'b0;
        sample_tvalid        = 1'b0;
        sample_tdata         = 16'h0;
        cfg_req              = 1'b0;
        cfg_word             = word;
        m_axis_config_tready = 1'b1;
        m_axis_data_tready   = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (m_axis_config_tvalid !== 1'b1 || m_axis_config_tdata !== word || sample_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_issue: got tvalid=%b tdata=%h sready=%b want 1 %h 0",
                     m_axis_config_tvalid, m_axis_config_tdata, sample_tready, word);
        end
        @(negedge aclk);
        n_cmp++;
        if (m_axis_config_tvalid !== 1'b0 || sample_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_done: got tvalid=%b sready=%b want 0 1",
                     m_axis_config_tvalid, sample_tready);
        end
        m_axis_config_tready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn              = 1'b0;
        sample_tvalid        = 1'b0;
        sample_tdata         = 16'h1234;
        cfg_req              = 1'b0;
        cfg_word             = 16'h0001;
        m_axis_config_tready = 1'b1;
        m_axis_data_tready   = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (m_axis_config_tvalid !== 1'b0 || m_axis_config_tdata !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_cfg: got %b/%h want 0/0000", m_axis_config_tvalid, m_axis_config_tdata);
        end
        n_cmp++;
        if (m_axis_data_tvalid !== 1'b0 || m_axis_data_tdata !== 64'h0 || m_axis_data_tlast !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_data: got %b/%h/%b want 0/0/0",
                     m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast);
        end
        n_cmp++;
        if (sample_tready !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_misc: got sready=%b done=%b count=%0d want 0 0 0",
                     sample_tready, frame_done, frame_count);
        end
        do_reset_and_config(16'h0001);
    endtask

    task automatic test_conversion();
        m_axis_data_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample_tdata  = conv_in[i];
            sample_tvalid = 1'b1;
            @(negedge aclk);
            n_cmp++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== {32'h0, conv_exp[i]}
                || m_axis_data_tlast !== 1'b0) begin
                n_bad++;
                $display("FAIL conv[%0d]: got v=%b d=%h l=%b want 1 %h 0", i,
                         m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast, {32'h0, conv_exp[i]});
            end
        end
        sample_tvalid = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (m_axis_data_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain: got tvalid=%b want 0", m_axis_data_tvalid);
        end
    endtask

    task automatic test_frame();
        int done_cnt;
        done_cnt = 0;
        do_reset_and_config(16'h0001);
        m_axis_data_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sample_tdata  = 16'(k);
            sample_tvalid = 1'b1;
            @(negedge aclk);
            if (frame_done === 1'b1) done_cnt++;
            n_cmp++;
            if (m_axis_data_tlast !== (k == 7 || k == 15)) begin
                n_bad++;
                $display("FAIL tlast[%0d]: got %b want %b", k, m_axis_data_tlast, (k == 7 || k == 15));
            end
            if (k == 16) begin
                n_cmp++;
                if (m_axis_data_tdata !== 64'h0000_0000_4180_0000) begin
                    n_bad++;
                    $display("FAIL beat16: got %h want 0000000041800000", m_axis_data_tdata);
                end
            end
        end
        sample_tvalid = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            if (frame_done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 2 || frame_count !== 16'd2) begin
            n_bad++;
            $display("FAIL frames: got done=%0d count=%0d want 2 2", done_cnt, frame_count);
        end
    endtask

    task automatic test_backpressure();
        int          in_idx;
        int          out_idx;
        int          cyc;
        logic        stall;
        logic [63:0] held_d;
        logic        held_l;
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stall   = 1'b0;
        held_d  = 64'h0;
        held_l  = 1'b0;
        do_reset_and_config(16'h0001);
        while (out_idx < 12 && cyc < 400) begin
            @(negedge aclk);
            cyc++;
            if (stall) begin
                n_cmp++;
                if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== held_d || m_axis_data_tlast !== held_l) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want 1 %h %b",
                             m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast, held_d, held_l);
                end
            end
            if (in_idx < 12) begin
                sample_tvalid = 1'b1;
                sample_tdata  = bp_in[in_idx];
            end else begin
                sample_tvalid = 1'b0;
            end
            m_axis_data_tready = 1'($urandom_range(0, 1));
            #1;
            if (m_axis_data_tvalid && m_axis_data_tready) begin
                n_cmp++;
                if (m_axis_data_tdata !== {32'h0, bp_exp[out_idx]} || m_axis_data_tlast !== ((out_idx % FL) == FL - 1)) begin
                    n_bad++;
                    $display("FAIL bp_beat[%0d]: got d=%h l=%b want %h %b", out_idx,
                             m_axis_data_tdata, m_axis_data_tlast, {32'h0, bp_exp[out_idx]},
                             ((out_idx % FL) == FL - 1));
                end
                out_idx++;
            end
            if (sample_tvalid && sample_tready) in_idx++;
            stall  = m_axis_data_tvalid && !m_axis_data_tready;
            held_d = m_axis_data_tdata;
            held_l = m_axis_data_tlast;
        end
        n_cmp++;
        if (out_idx != 12) begin
            n_bad++;
            $display("FAIL bp_count: got %0d beats want 12", out_idx);
        end
        sample_tvalid      = 1'b0;
        m_axis_data_tready = 1'b1;
    endtask

    task automatic test_cfg_req();
        int   accepted;
        int   cyc;
        logic pulsed;
        logic seen;
        accepted = 0;
        cyc      = 0;
        pulsed   = 1'b0;
        seen     = 1'b0;
        do_reset_and_config(16'h0001);
        m_axis_data_tready = 1'b1;
        while (cyc < 60) begin
            @(negedge aclk);
            cyc++;
            if (m_axis_config_tvalid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cfg_req = 1'b0;
            if (accepted == 3 && !pulsed) begin
                cfg_req  = 1'b1;
                cfg_word = 16'h0000;
                pulsed   = 1'b1;
            end
            sample_tvalid = 1'b1;
            sample_tdata  = 16'(accepted);
            #1;
            if (sample_tvalid && sample_tready) accepted++;
        end
        cfg_req = 1'b0;
        n_cmp++;
        if (!seen || accepted != 8 || m_axis_config_tdata !== 16'h0000 || frame_count !== 16'd1) begin
            n_bad++;
            $display("FAIL reconfig: got seen=%b accepted=%0d cfg=%h count=%0d want 1 8 0000 1",
                     seen, accepted, m_axis_config_tdata, frame_count);
        end
        repeat (3) begin
            @(negedge aclk);
            #1;
            n_cmp++;
            if (sample_tready !== 1'b0 || m_axis_config_tvalid !== 1'b1) begin
                n_bad++;
                $display("FAIL cfg_hold: got sready=%b cvalid=%b want 0 1", sample_tready, m_axis_config_tvalid);
            end
        end
        m_axis_config_tready = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (m_axis_config_tvalid !== 1'b0 || sample_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_resume: got cvalid=%b sready=%b want 0 1", m_axis_config_tvalid, sample_tready);
        end
        m_axis_config_tready = 1'b0;
        sample_tvalid        = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset_and_config(16'h0005);
        m_axis_data_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample_tdata  = 16'(k + 1);
            sample_tvalid = 1'b1;
            @(negedge aclk);
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_data_tvalid !== 1'b0 || m_axis_data_tdata !== 64'h0 || m_axis_data_tlast !== 1'b0
            || sample_tready !== 1'b0 || m_axis_config_tvalid !== 1'b0 || m_axis_config_tdata !== 16'h0) begin
            n_bad++;
            $display("FAIL async_rst: got dv=%b d=%h l=%b sr=%b cv=%b cd=%h want all 0",
                     m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast, sample_tready,
                     m_axis_config_tvalid, m_axis_config_tdata);
        end
        sample_tvalid = 1'b0;
        do_reset_and_config(16'h0005);
        m_axis_data_tready = 1'b1;
        for (int k = 0; k < FL; k++) begin
            sample_tdata  = 16'(k);
            sample_tvalid = 1'b1;
            @(negedge aclk);
            n_cmp++;
            if (m_axis_data_tlast !== (k == FL - 1)) begin
                n_bad++;
                $display("FAIL restart_tlast[%0d]: got %b want %b", k, m_axis_data_tlast, (k == FL - 1));
            end
        end
        sample_tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_frame();
        test_backpressure();
        test_cfg_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
